instruction_fetch_stage: RTL and testbench

Front pipeline stage ahead of instruction decode. It owns the program counter and issues one instruction-memory request at a time. It predicts the next PC with a direct-mapped branch target buffer (BTB) of 2-bit saturating counters. It delivers instruction, PC+4 and the prediction bit through a registered output slot backed by a one-entry skid buffer. Execute redirects it on mispredict, jump or return, and trains the BTB.

---
 rtl/instruction_fetch_stage.sv | 167 ++++++++++++++++
 tb/tb_instruction_fetch_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - PC owner, single-outstanding imem fetch, 2-bit BTB, output slot + skid
module instruction_fetch_stage #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          BTB_ENTRIES = 16,
   parameter int          BTB_IDX_W   = $clog2(BTB_ENTRIES)
) (
   input  logic        iClk,
   input  logic        iRst,
   output logic [31:0] oImemAddr,
   output logic        oImemReq,
   input  logic [31:0] iImemData,
   input  logic        iImemValid,
   input  logic        iStall,
   input  logic        iHalt,
   input  logic        iRedirect,
   input  logic [31:0] iRedirectPC,
   input  logic        iUpdateEn,
   input  logic [31:0] iUpdatePC,
   input  logic        iUpdateTaken,
   input  logic [31:0] iUpdateTarget,
   output logic [31:0] oInstruction,
   output logic [31:0] oNextPC,
   output logic        oBranchPredict,
   output logic        oValid
);
   localparam int TAG_W = 30 - BTB_IDX_W;

   logic [31:0] pc, reqPC, pcPlus4, nextFetch, respNextPC;
   logic        pending, discard, halted, reqPred;
   logic [31:0] skInstr, skNextPC;
   logic        skPred, skValid, skValidNext;
   logic        respLive, consume, predTaken;

   logic             btbValid  [BTB_ENTRIES];
   logic [TAG_W-1:0] btbTag    [BTB_ENTRIES];
   logic [31:0]      btbTarget [BTB_ENTRIES];
   logic [1:0]       btbCtr    [BTB_ENTRIES];

   logic [BTB_IDX_W-1:0] lkIdx, upIdx;
   logic [TAG_W-1:0]     lkTag, upTag;
   logic                 upHit;
   logic                 unusedUpdLsb;

   assign lkIdx     = pc[BTB_IDX_W+1:2];
   assign lkTag     = pc[31:BTB_IDX_W+2];
   assign predTaken = btbValid[lkIdx] && (btbTag[lkIdx] == lkTag) && btbCtr[lkIdx][1];
   assign pcPlus4   = pc + 32'd4;
   assign nextFetch = predTaken ? btbTarget[lkIdx] : pcPlus4;

   assign upIdx        = iUpdatePC[BTB_IDX_W+1:2];
   assign upTag        = iUpdatePC[31:BTB_IDX_W+2];
   assign upHit        = btbValid[upIdx] && (btbTag[upIdx] == upTag);
   assign unusedUpdLsb = ^iUpdatePC[1:0];

   assign respLive   = iImemValid && pending && !discard;
   assign consume    = !oValid || !iStall;
   assign respNextPC = reqPC + 32'd4;

   // Skid occupancy after this edge; a full skid blocks issue so it can never overflow.
   always_comb begin
      skValidNext = 1'b0;
      if (!iRedirect) begin
         if (consume) skValidNext = skValid && respLive;
         else         skValidNext = skValid || respLive;
      end
   end

   assign oImemAddr = pc;
   assign oImemReq  = !iRst && !iRedirect && !halted && !discard &&
                      (!pending || iImemValid) && !skValidNext;

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         pc             <= RESET_PC;
         reqPC          <= 32'd0;
         reqPred        <= 1'b0;
         pending        <= 1'b0;
         discard        <= 1'b0;
         halted         <= 1'b0;
         oValid         <= 1'b0;
         oInstruction   <= 32'd0;
         oNextPC        <= 32'd0;
         oBranchPredict <= 1'b0;
         skValid        <= 1'b0;
         skInstr        <= 32'd0;
         skNextPC       <= 32'd0;
         skPred         <= 1'b0;
      end else if (iRedirect) begin
         pc      <= iRedirectPC;
         halted  <= 1'b0;
         oValid  <= 1'b0;
         skValid <= 1'b0;
         // A still-outstanding response belongs to the flushed path and must be eaten on arrival.
         if (pending && !iImemValid) begin
            discard <= 1'b1;
         end else begin
            pending <= 1'b0;
            discard <= 1'b0;
         end
      end else begin
         if (iHalt) halted <= 1'b1;
         if (iImemValid && discard) begin
            discard <= 1'b0;
            pending <= 1'b0;
         end else if (oImemReq) begin
            pending <= 1'b1;
            reqPC   <= pc;
            reqPred <= predTaken;
            pc      <= nextFetch;
         end else if (iImemValid) begin
            pending <= 1'b0;
         end

         if (consume) begin
            if (skValid) begin
               oInstruction   <= skInstr;
               oNextPC        <= skNextPC;
               oBranchPredict <= skPred;
               oValid         <= 1'b1;
               skValid        <= respLive;
               if (respLive) begin
                  skInstr  <= iImemData;
                  skNextPC <= respNextPC;
                  skPred   <= reqPred;
               end
            end else if (respLive) begin
               oInstruction   <= iImemData;
               oNextPC        <= respNextPC;
               oBranchPredict <= reqPred;
               oValid         <= 1'b1;
            end else begin
               oValid <= 1'b0;
            end
         end else if (respLive) begin
            skInstr  <= iImemData;
            skNextPC <= respNextPC;
            skPred   <= reqPred;
            skValid  <= 1'b1;
         end
      end
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            btbValid[i[BTB_IDX_W-1:0]]  <= 1'b0;
            btbTag[i[BTB_IDX_W-1:0]]    <= '0;
            btbTarget[i[BTB_IDX_W-1:0]] <= 32'd0;
            btbCtr[i[BTB_IDX_W-1:0]]    <= 2'b00;
         end
      end else if (iUpdateEn) begin
         if (upHit) begin
            if (iUpdateTaken) begin
               btbCtr[upIdx]    <= (btbCtr[upIdx] == 2'b11) ? 2'b11 : btbCtr[upIdx] + 2'd1;
               btbTarget[upIdx] <= iUpdateTarget;
            end else begin
               btbCtr[upIdx] <= (btbCtr[upIdx] == 2'b00) ? 2'b00 : btbCtr[upIdx] - 2'd1;
            end
         end else if (iUpdateTaken) begin
            btbValid[upIdx]  <= 1'b1;
            btbTag[upIdx]    <= upTag;
            btbTarget[upIdx] <= iUpdateTarget;
            btbCtr[upIdx]    <= 2'b10;
         end
      end
   end
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - scoreboarded bench with a variable-latency memory model and BTB model
module tb_instruction_fetch_stage;
   logic        iClk = 1'b0;
   logic        iRst;
   logic [31:0] oImemAddr;
   logic        oImemReq;
   logic [31:0] iImemData;
   logic        iImemValid;
   logic        iStall, iHalt, iRedirect;
   logic [31:0] iRedirectPC;
   logic        iUpdateEn, iUpdateTaken;
   logic [31:0] iUpdatePC, iUpdateTarget;
   logic [31:0] oInstruction, oNextPC;
   logic        oBranchPredict, oValid;

   always #5 iClk = ~iClk;

   instruction_fetch_stage #(.RESET_PC(32'h0000_0100), .BTB_ENTRIES(16)) dut (
      .iClk(iClk), .iRst(iRst),
      .oImemAddr(oImemAddr), .oImemReq(oImemReq),
      .iImemData(iImemData), .iImemValid(iImemValid),
      .iStall(iStall), .iHalt(iHalt), .iRedirect(iRedirect), .iRedirectPC(iRedirectPC),
      .iUpdateEn(iUpdateEn), .iUpdatePC(iUpdatePC), .iUpdateTaken(iUpdateTaken),
      .iUpdateTarget(iUpdateTarget),
      .oInstruction(oInstruction), .oNextPC(oNextPC),
      .oBranchPredict(oBranchPredict), .oValid(oValid)
   );

   typedef struct { logic [31:0] instr; logic [31:0] npc; logic pred; } exp_t;
   typedef struct {
      logic stall; logic expReq; logic [31:0] expAddr;
      logic expValid; logic [31:0] expInstr; logic [31:0] expNpc;
   } vec_t;

   exp_t        sbq[$];
   logic [1:0]  mCtr [logic [31:0]];
   logic [31:0] mTgt [logic [31:0]];

   int nTests = 0, nFail = 0;
   int memLat = 1, memCnt = 0;
   logic [31:0] memAddr = 32'd0, expPC = 32'h100;
   logic [31:0] lastIss = 32'd0, prevIss = 32'd0, consumedNpc = 32'd0, consumedInstr = 32'd0;
   logic tbHalted = 1'b0, issued = 1'b0, respSeen = 1'b0, consumedFlag = 1'b0;
   logic prevHold = 1'b0, hPred = 1'b0;
   logic [31:0] hInstr = 32'd0, hNpc = 32'd0;
   logic gStall = 1'b0, gHalt = 1'b0, gRedir = 1'b0, gUpd = 1'b0, gUpdTaken = 1'b0;
   logic [31:0] gRpc = 32'd0, gUpdPC = 32'd0, gUpdTgt = 32'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] word(input logic [31:0] a);
      return 32'hA0 + ((a - 32'h100) >> 2);
   endfunction

   function automatic logic predict(input logic [31:0] a);
      logic [1:0] c;
      if (!mCtr.exists(a)) return 1'b0;
      c = mCtr[a];
      return c[1];
   endfunction

   task automatic modelUpdate();
      logic [1:0] c;
      if (mCtr.exists(gUpdPC)) begin
         c = mCtr[gUpdPC];
         if (gUpdTaken) begin
            mCtr[gUpdPC] = (c == 2'b11) ? c : c + 2'd1;
            mTgt[gUpdPC] = gUpdTgt;
         end else begin
            mCtr[gUpdPC] = (c == 2'b00) ? c : c - 2'd1;
         end
      end else if (gUpdTaken) begin
         mCtr[gUpdPC] = 2'b10;
         mTgt[gUpdPC] = gUpdTgt;
      end
   endtask

   // One cycle: drive at negedge, run the memory model, check outputs and issue.
   task automatic tick();
      exp_t e;
      logic p;
      @(negedge iClk);
      iStall = gStall; iHalt = gHalt; iRedirect = gRedir; iRedirectPC = gRpc;
      iUpdateEn = gUpd; iUpdatePC = gUpdPC; iUpdateTaken = gUpdTaken; iUpdateTarget = gUpdTgt;
      iImemValid = 1'b0;
      if (memCnt > 0) begin
         memCnt--;
         if (memCnt == 0) begin
            iImemValid = 1'b1;
            iImemData  = word(memAddr);
         end
      end
      #1;
      respSeen = iImemValid;
      consumedFlag = 1'b0;
      if (prevHold) begin
         chk("hold_valid", 32'(oValid), 32'd1);
         chk("hold_instr", oInstruction, hInstr);
         chk("hold_npc", oNextPC, hNpc);
         chk("hold_pred", 32'(oBranchPredict), 32'(hPred));
      end
      if (oValid && !iStall && !iRedirect) begin
         if (sbq.size() == 0) begin
            nTests++; nFail++;
            $display("FAIL unexpected_output: got %h, nothing expected", oInstruction);
         end else begin
            e = sbq.pop_front();
            chk("out_instr", oInstruction, e.instr);
            chk("out_npc", oNextPC, e.npc);
            chk("out_pred", 32'(oBranchPredict), 32'(e.pred));
            consumedFlag = 1'b1; consumedNpc = oNextPC; consumedInstr = oInstruction;
         end
      end
      issued = oImemReq;
      if (iRedirect)     chk("req_in_redirect", 32'(oImemReq), 32'd0);
      else if (tbHalted) chk("req_while_halted", 32'(oImemReq), 32'd0);
      if (oImemReq) begin
         chk("fetch_addr", oImemAddr, expPC);
         p = predict(oImemAddr);
         sbq.push_back('{word(oImemAddr), oImemAddr + 32'd4, p});
         memAddr = oImemAddr; memCnt = memLat;
         expPC = p ? mTgt[oImemAddr] : oImemAddr + 32'd4;
         prevIss = lastIss; lastIss = oImemAddr;
      end
      if (iRedirect) begin
         sbq.delete(); expPC = iRedirectPC; tbHalted = 1'b0;
      end else if (iHalt) begin
         tbHalted = 1'b1;
      end
      if (gUpd) modelUpdate();
      prevHold = oValid && iStall && !iRedirect;
      hInstr = oInstruction; hNpc = oNextPC; hPred = oBranchPredict;
      gRedir = 1'b0; gHalt = 1'b0; gUpd = 1'b0;
   endtask

   task automatic redirectTo(input logic [31:0] a);
      gRedir = 1'b1; gRpc = a;
      tick();
   endtask

   task automatic train(input logic [31:0] a, input logic t, input logic [31:0] tgt);
      gUpd = 1'b1; gUpdPC = a; gUpdTaken = t; gUpdTgt = tgt;
      tick();
   endtask

   task automatic seekPair(input string name, input logic [31:0] a, input logic [31:0] b);
      logic hit;
      hit = 1'b0;
      for (int c = 0; c < 25 && !hit; c++) begin
         tick();
         if (issued && prevIss == a && lastIss == b) hit = 1'b1;
      end
      chk(name, 32'(hit), 32'd1);
   endtask

   vec_t tbl[6];

   initial begin
      int cnt;
      logic done;
      iRst = 1'b1; iStall = 0; iHalt = 0; iRedirect = 0; iRedirectPC = 0;
      iUpdateEn = 0; iUpdatePC = 0; iUpdateTaken = 0; iUpdateTarget = 0;
      iImemValid = 0; iImemData = 0;
      tbl[0] = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h0,  32'h0};
      tbl[1] = '{1'b0, 1'b1, 32'h104, 1'b0, 32'h0,  32'h0};
      tbl[2] = '{1'b0, 1'b1, 32'h108, 1'b1, 32'hA0, 32'h104};
      tbl[3] = '{1'b0, 1'b1, 32'h10C, 1'b1, 32'hA1, 32'h108};
      tbl[4] = '{1'b0, 1'b1, 32'h110, 1'b1, 32'hA2, 32'h10C};
      tbl[5] = '{1'b0, 1'b1, 32'h114, 1'b1, 32'hA3, 32'h110};

      repeat (3) @(negedge iClk);
      #1;
      chk("rst_valid", 32'(oValid), 32'd0);
      chk("rst_instr", oInstruction, 32'd0);
      chk("rst_npc", oNextPC, 32'd0);
      chk("rst_pred", 32'(oBranchPredict), 32'd0);
      chk("rst_req", 32'(oImemReq), 32'd0);
      chk("rst_addr", oImemAddr, 32'h100);
      @(posedge iClk); #1 iRst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         gStall = tbl[i].stall;
         tick();
         chk("tbl_req", 32'(oImemReq), 32'(tbl[i].expReq));
         chk("tbl_addr", oImemAddr, tbl[i].expAddr);
         chk("tbl_valid", 32'(oValid), 32'(tbl[i].expValid));
         if (tbl[i].expValid) begin
            chk("tbl_instr", oInstruction, tbl[i].expInstr);
            chk("tbl_npc", oNextPC, tbl[i].expNpc);
         end
      end

      // Three-cycle stall mid-stream.
      cnt = 0;
      gStall = 1'b1;
      tick(); cnt += int'(respSeen);
      chk("stall_valid", 32'(oValid), 32'd1);
      tick(); cnt += int'(respSeen);
      chk("stall_req_skid_full", 32'(oImemReq), 32'd0);
      tick(); cnt += int'(respSeen);
      chk("stall_req_skid_full", 32'(oImemReq), 32'd0);
      chk("stall_resp_count", 32'(cnt <= 1), 32'd1);
      gStall = 1'b0;
      repeat (8) tick();

      // Redirect with stall, response and training in the same cycle.
      gStall = 1'b1;
      gUpd = 1'b1; gUpdPC = 32'h110; gUpdTaken = 1'b1; gUpdTgt = 32'h300;
      redirectTo(32'h100);
      gStall = 1'b0;
      tick();
      chk("redir_drops_output", 32'(oValid), 32'd0);
      seekPair("btb_taken_target", 32'h110, 32'h300);
      repeat (3) tick();
      train(32'h110, 1'b0, 32'h0);
      train(32'h110, 1'b0, 32'h0);
      train(32'h110, 1'b0, 32'h0);
      train(32'h110, 1'b1, 32'h300);
      redirectTo(32'h100);
      seekPair("btb_not_taken_fallthrough", 32'h110, 32'h114);

      // Latency-3 memory, redirect while a request is outstanding.
      memLat = 3;
      redirectTo(32'h100);
      done = 1'b0;
      for (int c = 0; c < 10 && !done; c++) begin tick(); done = issued; end
      chk("lat3_issue", 32'(done), 32'd1);
      redirectTo(32'h200);
      done = 1'b0; cnt = 0;
      for (int c = 0; c < 10 && !done; c++) begin tick(); cnt++; done = issued; end
      chk("redirect_gap", 32'(cnt), 32'd3);
      chk("redirect_addr", lastIss, 32'h200);
      done = 1'b0;
      for (int c = 0; c < 15 && !done; c++) begin tick(); done = consumedFlag; end
      chk("first_after_redirect", consumedInstr, word(32'h200));

      // Halt after the instruction at 0x108, then resume via redirect.
      memLat = 1;
      redirectTo(32'h100);
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         tick();
         done = consumedFlag && consumedNpc == 32'h10C;
      end
      chk("reach_0x108", 32'(done), 32'd1);
      gHalt = 1'b1;
      tick();
      cnt = 0;
      for (int c = 0; c < 6; c++) begin tick(); cnt += int'(issued); end
      chk("halt_no_req", 32'(cnt), 32'd0);
      chk("halt_drain", 32'(sbq.size()), 32'd0);
      redirectTo(32'h400);
      tick();
      chk("resume_issue", 32'(issued), 32'd1);
      chk("resume_addr", lastIss, 32'h400);

      // Reset with a request in flight and a trained BTB.
      train(32'h110, 1'b1, 32'h300);
      train(32'h110, 1'b1, 32'h300);
      memLat = 3;
      done = 1'b0;
      for (int c = 0; c < 10 && !done; c++) begin tick(); done = issued; end
      tick();
      #2 iRst = 1'b1;
      #1;
      chk("arst_valid", 32'(oValid), 32'd0);
      chk("arst_instr", oInstruction, 32'd0);
      chk("arst_npc", oNextPC, 32'd0);
      chk("arst_pred", 32'(oBranchPredict), 32'd0);
      chk("arst_req", 32'(oImemReq), 32'd0);
      iImemValid = 1'b0; memCnt = 0; memLat = 1;
      sbq.delete(); mCtr.delete(); mTgt.delete();
      expPC = 32'h100; tbHalted = 1'b0; prevHold = 1'b0;
      @(posedge iClk); #1 iRst = 1'b0;
      tick();
      chk("post_reset_req", 32'(issued), 32'd1);
      chk("post_reset_addr", lastIss, 32'h100);
      seekPair("post_reset_btb_empty", 32'h110, 32'h114);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", nTests);
      $fatal(1);
   end
endmodule
